grid_ad7490_emu: RTL and testbench
==================================

GRID_AD7490_EMU -- requirements
Module: grid_ad7490_emu

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- MOD_ID, 32'hEA680004, value returned at register 1.
- SYNC_STAGES, 2, flip-flop depth of each SPI input synchronizer (legal values 2..3).

REQ-002 Ports, one per line (name  direction  width  meaning):
- rsi_MRST_reset  in  1  reset; asynchronous, active-high.
- csi_MCLK_clk  in  1  clock; all logic runs on this clock.
- avs_ctrl_writedata  in  32  Avalon-MM write data.
- avs_ctrl_readdata  out  32  Avalon-MM read data, registered.
- avs_ctrl_address  in  4  word address.
- avs_ctrl_byteenable  in  4  write byte enables.
- avs_ctrl_write  in  1  write strobe.
- avs_ctrl_read  in  1  read strobe.
- avs_ctrl_waitrequest  out  1  tied 0.
- coe_SCLK  in  1  SPI clock from master; idles high.
- coe_CSN  in  1  SPI chip select, active-low.
- coe_DIN  in  1  SPI data from master.
- coe_DOUT  out  1  SPI data to master.

Function
REQ-003 The SCLK, CSN and DIN inputs shall each pass through SYNC_STAGES flip-flops before use. Edges shall be detected on the synchronized values. SCLK high and low phases are each at least 4 csi_MCLK_clk periods.

REQ-004 Register map, word addresses. readdata shall update one cycle after the address is presented, independent of avs_ctrl_read.
- 0: constant 64.
- 1: MOD_ID.
- 2: {15'b0, enable[16], last_ctrl[15:0]}. enable is R/W via byteenable[2], reset value 1. last_ctrl is RO.
- 3: {cur_addr[27:24], 7'b0, coding[16], 7'b0, range[8], 8'b0}. RO.
- 4: frame_cnt[15:0] and abort_cnt[31:16]. A write with any byteenable clears both counters.
- 8..15: at address 8+k, bits [31:20] = ch[2k+1] and bits [15:4] = ch[2k]. Bytes 3:2 are writable for the odd channel; bytes 1:0 for the even channel. Unused bits read 0.
- Any other address reads 0.

REQ-005 The frame state machine shall have states IDLE, ACTIVE and DONE.
- IDLE -> ACTIVE: on a synchronized CSN falling edge while enable=1.
- ACTIVE -> DONE: on the 16th synchronized SCLK falling edge.
- ACTIVE -> IDLE: on a CSN rising edge with fewer than 16 falling edges seen; abort_cnt shall increment.
- DONE -> IDLE: on a CSN rising edge.

REQ-006 On IDLE->ACTIVE, the block shall load the 16-bit shift-out word.
- Word = {cur_addr, odata}, where odata = ch[cur_addr] when coding=1, and ch[cur_addr] XOR 12'h800 when coding=0.
- coe_DOUT shall present bit 15 in the same cycle the state becomes ACTIVE.

REQ-007 In ACTIVE, each synchronized SCLK falling edge shall do two things:
- Sample synchronized DIN into the shift-in register, MSB first.
- Advance coe_DOUT to the next lower bit of the shift-out word one cycle later.

REQ-008 In DONE and IDLE, coe_DOUT shall be 0. Further SCLK edges in DONE shall be ignored.

REQ-009 On entering DONE, the shift-in word shall be copied to last_ctrl and frame_cnt shall increment, saturating at 16'hFFFF. If shift-in bit 15 (WRITE) = 1, the following shall update on the same cycle:
- cur_addr <= bits [13:10]
- range <= bit 5
- coding <= bit 4
If WRITE = 0, these fields shall hold.

REQ-010 abort_cnt shall saturate at 16'hFFFF.

REQ-011 When a counter increment and a clear via address 4 fall in the same cycle, the clear shall win.

REQ-012 An Avalon write to a channel register during ACTIVE shall not alter the word already loaded. The new value shall apply from the next frame.

REQ-013 A CSN falling edge while enable=0 shall leave the state IDLE with coe_DOUT = 0. Clearing enable during ACTIVE shall not abort the frame in progress.

REQ-014 Bits SEQ, PM1, PM0, SHADOW and WEAKTRI shall be captured in last_ctrl only; they have no other effect.

Reset
REQ-015 While rsi_MRST_reset is high, the block shall hold the following values:
- state IDLE; coe_DOUT 0; readdata 0.
- all ch 0; cur_addr 0; coding 1; range 0; enable 1.
- last_ctrl 0; both counters 0.
- synchronizer flip-flops: SCLK 1, CSN 1, DIN 0.

REQ-016 Reset asserted mid-frame shall abort the frame without incrementing abort_cnt. The block shall not enter ACTIVE until a new CSN falling edge occurs after reset is released.

Verification
REQ-017 Preload ch0 = 12'hABC. Run a frame shifting in 16'h8310 -> master reads 16'h0ABC; reg2 reads 0x00018310; reg3 cur_addr = 0, coding = 1; frame_cnt = 1.

REQ-018 Set ch5 = 12'h123. Run a frame with DIN 16'h9410 (ADD = 5), then a second frame -> the second frame returns 16'h5123. Then write 16'h9400 (coding = 0); the next frame returns 16'h5923.

REQ-019 Raise CSN after 9 SCLK falls -> abort_cnt = 1, frame_cnt unchanged, cur_addr unchanged, coe_DOUT = 0.

REQ-020 Run a frame with DIN 16'h7C10 (WRITE = 0) -> last_ctrl = 16'h7C10; cur_addr, range and coding unchanged.

REQ-021 Assert reset at the 8th SCLK fall -> all REQ-015 values are present. A full frame after reset returns 16'h0000.

REQ-022 Write reg4 on the same cycle as a frame completes -> both counters read 0 afterwards.

Source files
------------

// File: rtl/grid_ad7490_emu_if.sv
// Avalon-MM control bus for the AD7490 emulator.
// The host side drives master; the emulator takes slave.
interface grid_ad7490_emu_if;
  logic [31:0] avs_ctrl_writedata;
  logic [31:0] avs_ctrl_readdata;
  logic [3:0]  avs_ctrl_address;
  logic [3:0]  avs_ctrl_byteenable;
  logic        avs_ctrl_write;
  logic        avs_ctrl_read;
  logic        avs_ctrl_waitrequest;

  modport master (
    output avs_ctrl_writedata,
    output avs_ctrl_address,
    output avs_ctrl_byteenable,
    output avs_ctrl_write,
    output avs_ctrl_read,
    input  avs_ctrl_readdata,
    input  avs_ctrl_waitrequest
  );

  modport slave (
    input  avs_ctrl_writedata,
    input  avs_ctrl_address,
    input  avs_ctrl_byteenable,
    input  avs_ctrl_write,
    input  avs_ctrl_read,
    output avs_ctrl_readdata,
    output avs_ctrl_waitrequest
  );
endinterface

// File: rtl/grid_ad7490_emu.sv
// AD7490 SPI slave emulator: 16 host-loaded channels shifted out
// on the SPI bus, control word captured from the master.
module grid_ad7490_emu #(
  parameter logic [31:0] MOD_ID      = 32'hEA680004,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             rsi_MRST_reset,
  input  logic             csi_MCLK_clk,
  grid_ad7490_emu_if.slave avs,
  input  logic             coe_SCLK,
  input  logic             coe_CSN,
  input  logic             coe_DIN,
  output logic             coe_DOUT
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  localparam logic [2:0] ARM_N = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] csn_q;
  logic [SYNC_STAGES-1:0] din_q;
  logic                   sclk_d;
  logic                   csn_d;
  logic [2:0]             arm_cnt;

  logic sclk_s;
  logic csn_s;
  logic din_s;
  logic armed;
  logic sclk_fall;
  logic csn_fall;
  logic csn_rise;

  state_t      state;
  logic [15:0] sh_out;
  logic [14:0] sh_in;
  logic [3:0]  bit_cnt;
  logic [11:0] ch [16];
  logic [3:0]  cur_addr;
  logic        coding;
  logic        adc_range;
  logic        enable;
  logic [15:0] last_ctrl;
  logic [15:0] frame_cnt;
  logic [15:0] abort_cnt;
  logic [31:0] readdata;

  logic        wr;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [3:0]  addr;
  logic [3:0]  odd_i;
  logic [3:0]  even_i;
  logic        cnt_clr;
  logic [15:0] nxt_in;
  logic [11:0] odata;
  logic [15:0] load_word;
  logic [31:0] rd_next;
  logic        unused_ok;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign csn_s  = csn_q[SYNC_STAGES-1];
  assign din_s  = din_q[SYNC_STAGES-1];

  // Edges are ignored until the synchronizers have flushed their
  // reset values, so a CSN held low across reset is not a new frame.
  assign armed     = (arm_cnt == ARM_N);
  assign sclk_fall = armed & sclk_d & ~sclk_s;
  assign csn_fall  = armed & csn_d & ~csn_s;
  assign csn_rise  = armed & ~csn_d & csn_s;

  assign wr      = avs.avs_ctrl_write;
  assign be      = avs.avs_ctrl_byteenable;
  assign wd      = avs.avs_ctrl_writedata;
  assign addr    = avs.avs_ctrl_address;
  assign odd_i   = {addr[2:0], 1'b1};
  assign even_i  = {addr[2:0], 1'b0};
  assign cnt_clr = wr && (addr == 4'd4) && (|be);

  assign nxt_in    = {sh_in, din_s};
  assign odata     = coding ? ch[cur_addr] : (ch[cur_addr] ^ 12'h800);
  assign load_word = {cur_addr, odata};

  assign avs.avs_ctrl_readdata    = readdata;
  assign avs.avs_ctrl_waitrequest = 1'b0;

  assign unused_ok = avs.avs_ctrl_read
                   ^ (^wd[19:17])
                   ^ (^wd[3:0]);

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      sclk_q  <= '1;
      csn_q   <= '1;
      din_q   <= '0;
      sclk_d  <= 1'b1;
      csn_d   <= 1'b1;
      arm_cnt <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], coe_SCLK};
      csn_q  <= {csn_q[SYNC_STAGES-2:0], coe_CSN};
      din_q  <= {din_q[SYNC_STAGES-2:0], coe_DIN};
      sclk_d <= sclk_s;
      csn_d  <= csn_s;
      if (arm_cnt != ARM_N) begin
        arm_cnt <= arm_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state     <= IDLE;
      coe_DOUT  <= 1'b0;
      sh_out    <= '0;
      sh_in     <= '0;
      bit_cnt   <= '0;
      cur_addr  <= '0;
      coding    <= 1'b1;
      adc_range <= 1'b0;
      enable    <= 1'b1;
      last_ctrl <= '0;
      frame_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      // DOUT trails the shift register by one cycle.
      coe_DOUT <= (state == ACTIVE) ? sh_out[15] : 1'b0;
      unique case (state)
        IDLE: begin
          if (csn_fall && enable) begin
            state    <= ACTIVE;
            sh_out   <= load_word;
            coe_DOUT <= load_word[15];
            bit_cnt  <= '0;
          end
        end
        ACTIVE: begin
          if (csn_rise) begin
            state    <= IDLE;
            coe_DOUT <= 1'b0;
            if (abort_cnt != 16'hFFFF) begin
              abort_cnt <= abort_cnt + 16'd1;
            end
          end else if (sclk_fall) begin
            sh_in   <= nxt_in[14:0];
            sh_out  <= {sh_out[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state     <= DONE;
              last_ctrl <= nxt_in;
              if (frame_cnt != 16'hFFFF) begin
                frame_cnt <= frame_cnt + 16'd1;
              end
              if (nxt_in[15]) begin
                cur_addr  <= nxt_in[13:10];
                adc_range <= nxt_in[5];
                coding    <= nxt_in[4];
              end
            end
          end
        end
        DONE: begin
          if (csn_rise) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (wr && (addr == 4'd2) && be[2]) begin
        enable <= wd[16];
      end
      if (cnt_clr) begin
        frame_cnt <= '0;
        abort_cnt <= '0;
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      for (int i = 0; i < 16; i++) begin
        ch[i] <= '0;
      end
    end else if (wr && addr[3]) begin
      if (be[3]) ch[odd_i][11:4]  <= wd[31:24];
      if (be[2]) ch[odd_i][3:0]   <= wd[23:20];
      if (be[1]) ch[even_i][11:4] <= wd[15:8];
      if (be[0]) ch[even_i][3:0]  <= wd[7:4];
    end
  end

  always_comb begin
    rd_next = '0;
    case (addr)
      4'd0: rd_next = 32'd64;
      4'd1: rd_next = MOD_ID;
      4'd2: rd_next = {15'b0, enable, last_ctrl};
      4'd3: rd_next = {4'b0, cur_addr, 7'b0, coding,
                       7'b0, adc_range, 8'b0};
      4'd4: rd_next = {abort_cnt, frame_cnt};
      default: begin
        if (addr[3]) begin
          rd_next = {ch[odd_i], 4'b0, ch[even_i], 4'b0};
        end
      end
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_grid_ad7490_emu.sv
// Directed bench for grid_ad7490_emu: frame vectors from a table,
// hand sequences for abort, enable, mid-frame writes and reset.
module tb_grid_ad7490_emu;

  localparam int HALF = 6;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic [31:0] r2;
    logic [31:0] r3;
    logic [31:0] r4;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b1;
  logic csn = 1'b1;
  logic din = 1'b0;
  logic dout;

  int tests = 0;
  int fails = 0;

  logic        mid_en = 1'b0;
  logic [3:0]  mid_addr;
  logic [31:0] mid_data;
  logic [3:0]  mid_be;

  logic [15:0] got;
  logic [31:0] rd;
  logic [15:0] rw = 16'h8C00;
  vec_t        vt [8];

  grid_ad7490_emu_if bus ();

  grid_ad7490_emu dut (
    .rsi_MRST_reset (rst),
    .csi_MCLK_clk   (clk),
    .avs            (bus),
    .coe_SCLK       (sclk),
    .coe_CSN        (csn),
    .coe_DIN        (din),
    .coe_DOUT       (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic av_write(input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] b);
    @(posedge clk);
    #1;
    bus.avs_ctrl_address    = a;
    bus.avs_ctrl_writedata  = d;
    bus.avs_ctrl_byteenable = b;
    bus.avs_ctrl_write      = 1'b1;
    @(posedge clk);
    #1;
    bus.avs_ctrl_write      = 1'b0;
    bus.avs_ctrl_byteenable = 4'h0;
  endtask

  task automatic av_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk);
    #1;
    bus.avs_ctrl_address = a;
    bus.avs_ctrl_read    = 1'b1;
    @(posedge clk);
    #1;
    d = bus.avs_ctrl_readdata;
    bus.avs_ctrl_read = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    av_read(a, d);
    chk(nm, d, exp);
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nfalls,
                           input bit clr_last, output logic [15:0] q);
    q = '0;
    @(posedge clk);
    #1 csn = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < nfalls; i++) begin
      din = w[15-i];
      repeat (HALF) @(posedge clk);
      #1 q[15-i] = dout;
      if (mid_en && i == 4) begin
        av_write(mid_addr, mid_data, mid_be);
        mid_en = 1'b0;
      end
      sclk = 1'b0;
      if (clr_last && i == nfalls - 1) begin
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.avs_ctrl_address    = 4'd4;
        bus.avs_ctrl_writedata  = 32'h0;
        bus.avs_ctrl_byteenable = 4'hF;
        bus.avs_ctrl_write      = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_ctrl_write      = 1'b0;
        bus.avs_ctrl_byteenable = 4'h0;
        repeat (HALF - 3) @(posedge clk);
        #1;
      end else begin
        repeat (HALF) @(posedge clk);
        #1;
      end
      sclk = 1'b1;
    end
    repeat (HALF) @(posedge clk);
    #1 csn = 1'b1;
    din = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{16'h8310, 16'h0ABC, 32'h00018310, 32'h00010000, 32'h1};
    vt[1] = '{16'h9410, 16'h0ABC, 32'h00019410, 32'h05010000, 32'h2};
    vt[2] = '{16'h0000, 16'h5123, 32'h00010000, 32'h05010000, 32'h3};
    vt[3] = '{16'h9400, 16'h5123, 32'h00019400, 32'h05000000, 32'h4};
    vt[4] = '{16'h0000, 16'h5923, 32'h00010000, 32'h05000000, 32'h5};
    vt[5] = '{16'h7C10, 16'h5923, 32'h00017C10, 32'h05000000, 32'h6};
    vt[6] = '{16'h8C30, 16'h5923, 32'h00018C30, 32'h03010100, 32'h7};
    vt[7] = '{16'h0000, 16'h3000, 32'h00010000, 32'h03010100, 32'h8};

    bus.avs_ctrl_address    = 4'd0;
    bus.avs_ctrl_writedata  = 32'h0;
    bus.avs_ctrl_byteenable = 4'h0;
    bus.avs_ctrl_write      = 1'b0;
    bus.avs_ctrl_read       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 1'b0);
    chk("rst_rdata", bus.avs_ctrl_readdata, 32'h0);
    chk("waitreq", bus.avs_ctrl_waitrequest, 1'b0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    rd_chk("reg0", 4'd0, 32'd64);
    rd_chk("reg1", 4'd1, 32'hEA680004);
    rd_chk("reg2_rst", 4'd2, 32'h00010000);
    rd_chk("reg3_rst", 4'd3, 32'h00010000);
    rd_chk("reg4_rst", 4'd4, 32'h0);
    rd_chk("ch01_rst", 4'd8, 32'h0);

    av_write(4'd8, 32'h0000ABC0, 4'b0011);
    av_write(4'd10, 32'h12300000, 4'b1100);
    rd_chk("ch01", 4'd8, 32'h0000ABC0);
    rd_chk("ch45", 4'd10, 32'h12300000);
    rd_chk("reg5", 4'd5, 32'h0);
    rd_chk("reg7", 4'd7, 32'h0);

    for (int i = 0; i < 8; i++) begin
      spi_frame(vt[i].din, 16, 1'b0, got);
      chk($sformatf("v%0d_dout", i), got, vt[i].dout);
      rd_chk($sformatf("v%0d_reg2", i), 4'd2, vt[i].r2);
      rd_chk($sformatf("v%0d_reg3", i), 4'd3, vt[i].r3);
      rd_chk($sformatf("v%0d_reg4", i), 4'd4, vt[i].r4);
    end

    // Channel write while the word for ch3 is already shifting.
    mid_en   = 1'b1;
    mid_addr = 4'd9;
    mid_data = 32'h77700000;
    mid_be   = 4'b1100;
    spi_frame(16'h0000, 16, 1'b0, got);
    chk("mid_old", got, 16'h3000);
    spi_frame(16'h0000, 16, 1'b0, got);
    chk("mid_new", got, 16'h3777);

    spi_frame(16'h9C00, 9, 1'b0, got);
    chk("abort_dout", dout, 1'b0);
    chk("abort_bits", got, 16'h3700);
    rd_chk("abort_reg4", 4'd4, 32'h0001000A);
    rd_chk("abort_reg3", 4'd3, 32'h03010100);
    rd_chk("abort_reg2", 4'd2, 32'h00010000);

    av_write(4'd2, 32'h00000000, 4'b0100);
    spi_frame(16'h8000, 16, 1'b0, got);
    chk("dis_dout", got, 16'h0000);
    rd_chk("dis_reg4", 4'd4, 32'h0001000A);
    rd_chk("dis_reg2", 4'd2, 32'h00000000);

    av_write(4'd2, 32'h00010000, 4'b0100);
    mid_en   = 1'b1;
    mid_addr = 4'd2;
    mid_data = 32'h00000000;
    mid_be   = 4'b0100;
    spi_frame(16'h0000, 16, 1'b0, got);
    chk("endis_dout", got, 16'h3777);
    rd_chk("endis_reg4", 4'd4, 32'h0001000B);
    rd_chk("endis_reg2", 4'd2, 32'h00000000);
    av_write(4'd2, 32'h00010000, 4'b0100);

    spi_frame(16'h0000, 16, 1'b1, got);
    chk("clr_dout", got, 16'h3777);
    rd_chk("clr_reg4", 4'd4, 32'h0);

    // Reset lands in the middle of a frame.
    @(posedge clk);
    #1;
    bus.avs_ctrl_address = 4'd0;
    csn = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      din = rw[15-i];
      repeat (HALF) @(posedge clk);
      #1 sclk = 1'b0;
      if (i < 7) begin
        repeat (HALF) @(posedge clk);
        #1 sclk = 1'b1;
      end
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_dout", dout, 1'b0);
    chk("mrst_rdata", bus.avs_ctrl_readdata, 32'h0);
    csn  = 1'b1;
    sclk = 1'b1;
    din  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rd_chk("mrst_reg2", 4'd2, 32'h00010000);
    rd_chk("mrst_reg3", 4'd3, 32'h00010000);
    rd_chk("mrst_reg4", 4'd4, 32'h0);
    rd_chk("mrst_ch01", 4'd8, 32'h0);
    rd_chk("mrst_ch45", 4'd10, 32'h0);
    spi_frame(16'h0000, 16, 1'b0, got);
    chk("post_rst_dout", got, 16'h0000);
    rd_chk("post_rst_reg4", 4'd4, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
